fp_round_stage: RTL and testbench
=================================

// Module: fp_round_stage
// PURPOSE
//  Pipelined rounding/packing stage downstream of the FP adder's unrounded output.
//  - Consumes a uround_res_t: pre-round value, round/sticky bits, round_en, invalid, exp_cout.
//  - Applies the IEEE-754 rounding mode and detects overflow/underflow.
//  - Produces the final encoding plus fflags through a 2-stage valid/ready pipeline.
// PARAMETERS
//  FP_FORMAT  FP32  fp_format_e; FP_WIDTH/EXP_WIDTH/MANT_WIDTH are derived via fp_width/exp_bits/man_bits
// PORTS
//  clk_i         in   1         clock; single clock domain, all state on rising edge
//  rst_i         in   1         reset, synchronous, active-high
//  valid_i       in   1         urnd_i/rnd_i valid
//  ready_o       out  1         stage can accept; transfer when valid_i&ready_o
//  urnd_i        in   uround_res_t  unrounded result bundle (FP_FORMAT)
//  rnd_i         in   roundmode_e   rounding mode, captured with urnd_i
//  valid_o       out  1         result_o/fflags_o valid
//  ready_i       in   1         downstream accepts; transfer when valid_o&ready_i
//  result_o      out  FP_WIDTH  rounded encoding
//  fflags_o      out  5         {NV,DZ,OF,UF,NX}; DZ is always 0
// BEHAVIOUR
//  - Reset: all valid bits 0; result_o=0; fflags_o=0; any in-flight data is dropped. Reset has priority over handshakes in the same cycle.
//  - Latency: 2 cycles from input transfer to valid_o, with no stalls.
//  - Throughput: 1 result/cycle.
//  - Stage S1 registers: sign, {exp,mant}, inc, nx, ovf_pre, unf_pre, invalid, round_en, rnd.
//  - Stage S2 registers: final result_o and fflags_o.
//  - Each stage loads when it is empty or its content leaves in the same cycle (s_adv = ~v | next_adv).
//  - While valid_o=1 and ready_i=0, result_o/fflags_o/valid_o hold stable. No data is lost or reordered.
//  - Rounding increment (lsb=mant[0], r=rs[1], s=rs[0]):
//     RNE: r&(s|lsb); RTZ: 0; RDN: (r|s)&sign; RUP: (r|s)&~sign; RMM: r. Any other code is treated as RNE.
//  - Increment arithmetic: {exp,mant}+inc on EXP_WIDTH+MANT_WIDTH bits, so a mantissa carry propagates into exp.
//  - Overflow (OF|NX): exp_cout==2'b01, or rounded exp==all-ones. Result:
//     RNE/RMM -> +/-Inf; RTZ -> +/-max finite;
//     RDN -> +max finite or -Inf; RUP -> +Inf or -max finite.
//  - Underflow: exp_cout==2'b11 -> signed zero, UF|NX.
//  - Tiny inexact: rounded exp==0 and (r|s) -> UF|NX, result kept.
//  - NX = r|s when round_en; OF also forces NX.
//  - invalid=1 -> result = canonical qNaN {0,all-ones exp,1,0...}; fflags = NV only. Overrides all other cases.
//  - round_en=0 -> u_result passed unchanged; only NV may be set.
//  - Simultaneous input and output transfer on a full pipe: accepted; the pipe stays full.
// CONFIGURATION
//  FP_ROUND_SKID_EN defined:
//   - A 2-entry skid buffer sits in front of S1; ready_o is a flop output (= skid not full).
//   - Latency becomes 3 cycles.
//  FP_ROUND_SKID_EN undefined:
//   - ready_o = ~s1_valid | s1_adv (combinational from ready_i).
//   - Latency 2.
// STRUCTURE
//  - fp_pkg gains:
//     - fflags_t packed struct {nv,dz,of,uf,nx};
//     - function canon_nan(fmt);
//     - function max_finite(fmt,sign).
//  - Sub-module fp_round_core (combinational):
//     - computes inc and the overflow/underflow decision from sign, mant[0], rs, rnd, exp_cout;
//     - instantiated in S1.
// TESTING (FP32 unless noted)
//  - 0x3F800001, rs=10, RNE -> 0x3F800002, NX; 0x3F800000, rs=10, RNE -> 0x3F800000, NX (tie to even).
//  - 0x3FFFFFFF, rs=11, RUP -> 0x40000000, NX (mantissa carry into exp); same input with RTZ -> 0x3FFFFFFF, NX.
//  - 0x7F7FFFFF, rs=11: RNE -> 0x7F800000, OF|NX; RTZ -> 0x7F7FFFFF, OF|NX; 0xFF7FFFFF with RUP -> 0xFF7FFFFF, OF|NX.
//  - invalid=1, any value -> 0x7FC00000, fflags=10000; exp_cout=11, sign=1 -> 0x80000000, UF|NX.
//  - 6 back-to-back inputs, ready_i low for 3 cycles mid-stream -> all 6 out in order; valid_o/result_o stable while stalled; ready_o drops per CONFIGURATION.
//  - rst_i asserted 1 cycle with 2 items in flight -> next cycle valid_o=0, result_o=0, fflags_o=0; the following input yields correct result after latency.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fp_pkg
//  Description : Shared floating-point types and helpers for the rounding
//                stage: format/rounding-mode enums, the unrounded result
//                bundle, the exception-flag struct and encoding helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP64 = 2'd1,
    FP16 = 2'd2,
    BF16 = 2'd3
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } roundmode_e;

  // Widest supported encoding; narrower formats are right-aligned.
  localparam int FP_MAX_WIDTH = 64;

  // Unrounded adder output. exp_cout: 00 in range, 01 overflow, 11 underflow.
  typedef struct packed {
    logic [FP_MAX_WIDTH-1:0] u_result;
    logic [1:0]              rs;
    logic                    round_en;
    logic                    invalid;
    logic [1:0]              exp_cout;
  } uround_res_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  function automatic int exp_bits(fp_format_e fmt);
    int r;
    case (fmt)
      FP64:    r = 11;
      FP16:    r = 5;
      BF16:    r = 8;
      default: r = 8;
    endcase
    return r;
  endfunction

  function automatic int man_bits(fp_format_e fmt);
    int r;
    case (fmt)
      FP64:    r = 52;
      FP16:    r = 10;
      BF16:    r = 7;
      default: r = 23;
    endcase
    return r;
  endfunction

  function automatic int fp_width(fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB only.
  function automatic logic [FP_MAX_WIDTH-1:0] canon_nan(fp_format_e fmt);
    logic [FP_MAX_WIDTH-1:0] v;
    int m;
    int e;
    m = man_bits(fmt);
    e = exp_bits(fmt);
    v = '0;
    for (int i = 0; i < FP_MAX_WIDTH; i++) begin
      if ((i >= m) && (i < m + e)) v[i] = 1'b1;
    end
    v[m-1] = 1'b1;
    return v;
  endfunction

  // Largest finite magnitude: exponent all ones except LSB, mantissa all ones.
  function automatic logic [FP_MAX_WIDTH-1:0] max_finite(fp_format_e fmt, logic sign);
    logic [FP_MAX_WIDTH-1:0] v;
    int m;
    int e;
    m = man_bits(fmt);
    e = exp_bits(fmt);
    v = '0;
    for (int i = 0; i < FP_MAX_WIDTH; i++) begin
      if ((i < m) || ((i > m) && (i < m + e))) v[i] = 1'b1;
    end
    v[m+e] = sign;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_round_core.sv
`default_nettype none
// ============================================================================
//  Module      : fp_round_core
//  Description : Combinational rounding decision: increment bit from the
//                rounding mode, sign, LSB and round/sticky bits, plus the
//                pre-round overflow/underflow indication from exp_cout.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_round_core
  import fp_pkg::*;
(
  input  logic       sign_i,
  input  logic       lsb_i,
  input  logic [1:0] rs_i,
  input  roundmode_e rnd_i,
  input  logic [1:0] exp_cout_i,
  output logic       inc_o,
  output logic       ovf_pre_o,
  output logic       unf_pre_o
);

  logic w_r;
  logic w_s;

  assign w_r = rs_i[1];
  assign w_s = rs_i[0];

  // Increment selection; unknown mode codes fall back to round-to-nearest-even.
  always_comb begin
    inc_o = 1'b0;
    case (rnd_i)
      RTZ:     inc_o = 1'b0;
      RDN:     inc_o = (w_r | w_s) & sign_i;
      RUP:     inc_o = (w_r | w_s) & ~sign_i;
      RMM:     inc_o = w_r;
      default: inc_o = w_r & (w_s | lsb_i);
    endcase
  end

  assign ovf_pre_o = (exp_cout_i == 2'b01);
  assign unf_pre_o = (exp_cout_i == 2'b11);

endmodule
`default_nettype wire

// File: rtl/fp_round_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fp_round_stage
//  Description : Two-stage valid/ready rounding and packing stage behind the
//                FP adder. S1 captures the operand and rounding decision,
//                S2 applies the increment, resolves overflow/underflow/NaN
//                and registers result and fflags {NV,DZ,OF,UF,NX}.
//                Optional macro FP_ROUND_SKID_EN inserts a 2-entry skid
//                buffer ahead of S1 (registered ready_o, latency 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_round_stage
  import fp_pkg::*;
#(
  parameter  fp_format_e FP_FORMAT = FP32,
  localparam int         FP_WIDTH  = fp_width(FP_FORMAT)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  uround_res_t         urnd_i,
  input  roundmode_e          rnd_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [FP_WIDTH-1:0] result_o,
  output logic [4:0]          fflags_o
);

  localparam int EXP_WIDTH  = exp_bits(FP_FORMAT);
  localparam int MANT_WIDTH = man_bits(FP_FORMAT);
  localparam int EM_WIDTH   = EXP_WIDTH + MANT_WIDTH;

  localparam logic [FP_MAX_WIDTH-1:0] NAN_FULL    = canon_nan(FP_FORMAT);
  localparam logic [FP_MAX_WIDTH-1:0] MAXF_P_FULL = max_finite(FP_FORMAT, 1'b0);
  localparam logic [FP_MAX_WIDTH-1:0] MAXF_N_FULL = max_finite(FP_FORMAT, 1'b1);
  localparam logic [FP_WIDTH-1:0]     NAN_VAL     = NAN_FULL[FP_WIDTH-1:0];
  localparam logic [FP_WIDTH-1:0]     MAXF_POS    = MAXF_P_FULL[FP_WIDTH-1:0];
  localparam logic [FP_WIDTH-1:0]     MAXF_NEG    = MAXF_N_FULL[FP_WIDTH-1:0];

  // Handshake advance terms: a stage loads when empty or draining this cycle.
  logic w_s1_adv;
  logic w_s2_adv;

  // Item presented to S1 (directly from the port, or from the skid buffer).
  logic        w_in_valid;
  uround_res_t w_in_urnd;
  roundmode_e  w_in_rnd;

  // S1 state
  logic                s1_valid_q;
  logic                s1_sign_q;
  logic [EM_WIDTH-1:0] s1_em_q;
  logic                s1_inc_q;
  logic                s1_nx_q;
  logic                s1_ovf_pre_q;
  logic                s1_unf_pre_q;
  logic                s1_invalid_q;
  logic                s1_round_en_q;
  roundmode_e          s1_rnd_q;

  // S2 state
  logic                s2_valid_q;
  logic [FP_WIDTH-1:0] result_q;
  logic [4:0]          fflags_q;

  assign w_s2_adv = ~s2_valid_q | ready_i;
  assign w_s1_adv = ~s1_valid_q | w_s2_adv;

`ifdef FP_ROUND_SKID_EN
  typedef struct packed {
    uround_res_t urnd;
    roundmode_e  rnd;
  } skid_ent_t;

  skid_ent_t  skid_mem_q [2];
  logic       skid_wr_ptr_q;
  logic       skid_rd_ptr_q;
  logic [1:0] skid_cnt_q;
  logic [1:0] skid_cnt_d;
  logic       skid_rdy_q;
  logic       w_push;
  logic       w_pop;

  // ready_o only asserts when a free slot exists, so a push never overflows.
  assign w_push     = valid_i & skid_rdy_q;
  assign w_pop      = (skid_cnt_q != 2'd0) & w_s1_adv;
  assign skid_cnt_d = skid_cnt_q + {1'b0, w_push} - {1'b0, w_pop};

  // Skid FIFO bookkeeping and registered ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skid_wr_ptr_q <= 1'b0;
      skid_rd_ptr_q <= 1'b0;
      skid_cnt_q    <= 2'd0;
      skid_rdy_q    <= 1'b1;
    end else begin
      if (w_push) begin
        skid_mem_q[skid_wr_ptr_q] <= '{urnd: urnd_i, rnd: rnd_i};
        skid_wr_ptr_q             <= ~skid_wr_ptr_q;
      end
      if (w_pop) begin
        skid_rd_ptr_q <= ~skid_rd_ptr_q;
      end
      skid_cnt_q <= skid_cnt_d;
      skid_rdy_q <= (skid_cnt_d != 2'd2);
    end
  end

  assign w_in_valid = (skid_cnt_q != 2'd0);
  assign w_in_urnd  = skid_mem_q[skid_rd_ptr_q].urnd;
  assign w_in_rnd   = skid_mem_q[skid_rd_ptr_q].rnd;
  assign ready_o    = skid_rdy_q;
`else
  assign w_in_valid = valid_i;
  assign w_in_urnd  = urnd_i;
  assign w_in_rnd   = rnd_i;
  assign ready_o    = w_s1_adv;
`endif

  // Upper bits of the bundle are padding for narrower formats.
  generate
    if (FP_WIDTH < FP_MAX_WIDTH) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^w_in_urnd.u_result[FP_MAX_WIDTH-1:FP_WIDTH];
    end
  endgenerate

  logic                w_in_sign;
  logic [EM_WIDTH-1:0] w_in_em;
  logic                w_inc;
  logic                w_ovf_pre;
  logic                w_unf_pre;

  assign w_in_sign = w_in_urnd.u_result[FP_WIDTH-1];
  assign w_in_em   = w_in_urnd.u_result[EM_WIDTH-1:0];

  fp_round_core u_core (
    .sign_i     (w_in_sign),
    .lsb_i      (w_in_em[0]),
    .rs_i       (w_in_urnd.rs),
    .rnd_i      (w_in_rnd),
    .exp_cout_i (w_in_urnd.exp_cout),
    .inc_o      (w_inc),
    .ovf_pre_o  (w_ovf_pre),
    .unf_pre_o  (w_unf_pre)
  );

  // S1: capture operand and rounding decision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_em_q       <= '0;
      s1_inc_q      <= 1'b0;
      s1_nx_q       <= 1'b0;
      s1_ovf_pre_q  <= 1'b0;
      s1_unf_pre_q  <= 1'b0;
      s1_invalid_q  <= 1'b0;
      s1_round_en_q <= 1'b0;
      s1_rnd_q      <= RNE;
    end else if (w_s1_adv) begin
      s1_valid_q <= w_in_valid;
      if (w_in_valid) begin
        s1_sign_q     <= w_in_sign;
        s1_em_q       <= w_in_em;
        s1_inc_q      <= w_inc;
        s1_nx_q       <= (|w_in_urnd.rs) & w_in_urnd.round_en;
        s1_ovf_pre_q  <= w_ovf_pre;
        s1_unf_pre_q  <= w_unf_pre;
        s1_invalid_q  <= w_in_urnd.invalid;
        s1_round_en_q <= w_in_urnd.round_en;
        s1_rnd_q      <= w_in_rnd;
      end
    end
  end

  logic [EM_WIDTH-1:0]  w_em_rnd;
  logic [EXP_WIDTH-1:0] w_exp_rnd;
  logic                 w_ovf;
  logic                 w_to_inf;
  logic [FP_WIDTH-1:0]  w_result;
  fflags_t              w_flags;

  // S2 next value: apply increment and resolve special cases by priority
  // invalid > pass-through > underflow > overflow > normal rounding.
  always_comb begin
    w_em_rnd  = s1_em_q + {{(EM_WIDTH-1){1'b0}}, s1_inc_q};
    w_exp_rnd = w_em_rnd[EM_WIDTH-1:MANT_WIDTH];
    w_ovf     = s1_ovf_pre_q | (&w_exp_rnd);
    case (s1_rnd_q)
      RTZ:     w_to_inf = 1'b0;
      RDN:     w_to_inf = s1_sign_q;
      RUP:     w_to_inf = ~s1_sign_q;
      default: w_to_inf = 1'b1;
    endcase
    w_flags  = '0;
    w_result = {s1_sign_q, w_em_rnd};
    if (s1_invalid_q) begin
      w_result   = NAN_VAL;
      w_flags.nv = 1'b1;
    end else if (!s1_round_en_q) begin
      w_result = {s1_sign_q, s1_em_q};
    end else if (s1_unf_pre_q) begin
      w_result   = {s1_sign_q, {EM_WIDTH{1'b0}}};
      w_flags.uf = 1'b1;
      w_flags.nx = 1'b1;
    end else if (w_ovf) begin
      if (w_to_inf) begin
        w_result = {s1_sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      end else begin
        w_result = s1_sign_q ? MAXF_NEG : MAXF_POS;
      end
      w_flags.of = 1'b1;
      w_flags.nx = 1'b1;
    end else begin
      w_flags.nx = s1_nx_q;
      w_flags.uf = s1_nx_q & ~(|w_exp_rnd);
    end
  end

  // S2: register final encoding and flags; hold while downstream stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      fflags_q   <= '0;
    end else if (w_s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= w_result;
        fflags_q <= w_flags;
      end
    end
  end

  assign valid_o  = s2_valid_q;
  assign result_o = result_q;
  assign fflags_o = fflags_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_round_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_round_stage
//  Description : Directed self-checking bench for fp_round_stage (FP32):
//                rounding modes, carry, overflow/underflow, NaN, streaming
//                with backpressure and reset with items in flight.
//                Honours FP_ROUND_SKID_EN for the expected latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_round_stage;
  import fp_pkg::*;

`ifdef FP_ROUND_SKID_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int NVEC = 18;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  uround_res_t urnd_i;
  roundmode_e  rnd_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] val;
    logic [1:0]  rs;
    logic        re;
    logic        inv;
    logic [1:0]  ec;
    roundmode_e  rm;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;

  vec_t vt [NVEC];

  always #5 clk = ~clk;

  fp_round_stage #(.FP_FORMAT(FP32)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .urnd_i   (urnd_i),
    .rnd_i    (rnd_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .fflags_o (fflags_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input vec_t v);
    urnd_i                = '0;
    urnd_i.u_result[31:0] = v.val;
    urnd_i.rs             = v.rs;
    urnd_i.round_en       = v.re;
    urnd_i.invalid        = v.inv;
    urnd_i.exp_cout       = v.ec;
    rnd_i                 = v.rm;
  endtask

  // Single item through an empty pipe: latency, result, flags.
  task automatic run_vec(input int k);
    int lat;
    @(negedge clk);
    ready_i = 1'b1;
    drive(vt[k]);
    valid_i = 1'b1;
    #1;
    chk($sformatf("ready_o v%0d", k), {31'b0, ready_o}, 32'h1);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      valid_i = 1'b0;
      if (valid_o) break;
    end
    chk($sformatf("latency v%0d", k), lat, LAT);
    chk($sformatf("result v%0d", k), result_o, vt[k].res);
    chk($sformatf("fflags v%0d", k), {27'b0, fflags_o}, {27'b0, vt[k].fl});
  endtask

  initial begin
    int          sent;
    int          got;
    int          nrdy_low;
    int          k;
    logic        held_v;
    logic [31:0] held_res;
    logic [4:0]  held_fl;
    logic [31:0] exp_res;
    logic [4:0]  exp_fl;
    int          exp_q[$];

    //              val           rs     re    inv   ec     rm    res           fl
    vt[0]  = '{32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800002, 5'b00001};
    vt[1]  = '{32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800000, 5'b00001};
    vt[2]  = '{32'h3FFFFFFF, 2'b11, 1'b1, 1'b0, 2'b00, RUP, 32'h40000000, 5'b00001};
    vt[3]  = '{32'h3FFFFFFF, 2'b11, 1'b1, 1'b0, 2'b00, RTZ, 32'h3FFFFFFF, 5'b00001};
    vt[4]  = '{32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00, RNE, 32'h7F800000, 5'b00101};
    vt[5]  = '{32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, RTZ, 32'h7F7FFFFF, 5'b00101};
    vt[6]  = '{32'hFF7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, RUP, 32'hFF7FFFFF, 5'b00101};
    vt[7]  = '{32'h12345678, 2'b11, 1'b1, 1'b1, 2'b01, RNE, 32'h7FC00000, 5'b10000};
    vt[8]  = '{32'h80000005, 2'b01, 1'b1, 1'b0, 2'b11, RNE, 32'h80000000, 5'b00011};
    vt[9]  = '{32'h3F800001, 2'b11, 1'b0, 1'b0, 2'b00, RUP, 32'h3F800001, 5'b00000};
    vt[10] = '{32'hBF800000, 2'b01, 1'b1, 1'b0, 2'b00, RDN, 32'hBF800001, 5'b00001};
    vt[11] = '{32'h7F7FFFFF, 2'b00, 1'b1, 1'b0, 2'b01, RDN, 32'h7F7FFFFF, 5'b00101};
    vt[12] = '{32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, RMM, 32'h3F800001, 5'b00001};
    vt[13] = '{32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, roundmode_e'(3'd7), 32'h3F800000, 5'b00001};
    vt[14] = '{32'h00000001, 2'b01, 1'b1, 1'b0, 2'b00, RNE, 32'h00000001, 5'b00011};
    vt[15] = '{32'hFF7FFFFF, 2'b11, 1'b1, 1'b0, 2'b01, RDN, 32'hFF800000, 5'b00101};
    vt[16] = '{32'h40490FDB, 2'b00, 1'b1, 1'b0, 2'b00, RNE, 32'h40490FDB, 5'b00000};
    vt[17] = '{32'h7F7FFFFF, 2'b01, 1'b1, 1'b0, 2'b00, RUP, 32'h7F800000, 5'b00101};

    // Reset state
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    urnd_i  = '0;
    rnd_i   = RNE;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("reset valid_o", {31'b0, valid_o}, 32'h0);
    chk("reset result_o", result_o, 32'h0);
    chk("reset fflags_o", {27'b0, fflags_o}, 32'h0);
    chk("reset ready_o", {31'b0, ready_o}, 32'h1);

    // Directed single vectors
    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Stream of 6 with ready_i low for cycles 4..6
    sent     = 0;
    got      = 0;
    nrdy_low = 0;
    held_v   = 1'b0;
    held_res = '0;
    held_fl  = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      ready_i = !(c >= 4 && c <= 6);
      if (sent < 6) begin
        drive(vt[sent]);
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      #1;
      if (held_v) begin
        chk($sformatf("stall valid c%0d", c), {31'b0, valid_o}, 32'h1);
        chk($sformatf("stall result c%0d", c), result_o, held_res);
        chk($sformatf("stall fflags c%0d", c), {27'b0, fflags_o}, {27'b0, held_fl});
      end
      held_v   = valid_o & ~ready_i;
      held_res = result_o;
      held_fl  = fflags_o;
      if (valid_o && ready_i) begin
        if (exp_q.size() > 0) begin
          k       = exp_q.pop_front();
          exp_res = vt[k].res;
          exp_fl  = vt[k].fl;
        end else begin
          exp_res = 'x;
          exp_fl  = 'x;
        end
        chk($sformatf("stream result #%0d", got), result_o, exp_res);
        chk($sformatf("stream fflags #%0d", got), {27'b0, fflags_o}, {27'b0, exp_fl});
        got++;
      end
      if (valid_i && !ready_o) nrdy_low++;
      if (valid_i && ready_o) begin
        exp_q.push_back(sent);
        sent++;
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    chk("stream count", got, 6);
    chk("stream ready_o dropped", {31'b0, (nrdy_low > 0)}, 32'h1);

    // Reset with two items in flight; a third offered during reset is dropped
    @(negedge clk);
    drive(vt[2]);
    valid_i = 1'b1;
    @(negedge clk);
    drive(vt[4]);
    @(negedge clk);
    drive(vt[0]);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i   = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("inflight reset valid_o", {31'b0, valid_o}, 32'h0);
    chk("inflight reset result_o", result_o, 32'h0);
    chk("inflight reset fflags_o", {27'b0, fflags_o}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post-reset idle %0d", i), {31'b0, valid_o}, 32'h0);
    end
    run_vec(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
